// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- raster timing bundle from the VGA timing source to the
// sprite/palette renderers.
//   hs, vs       sync outputs, active level set by the generator's SYNC_POL
//   blank        1 = visible pixel, 0 = blanking interval
//   DrawX/DrawY  current horizontal / vertical count
//   line_start   1-cycle pulse when the raster steps to the start of a line
//   frame_start  1-cycle pulse when the raster steps to pixel (0,0)
//   frame_count  completed-frame count (wraps)
// master: the timing generator; slave: any consumer of the raster timing.
interface vga_timing_gen_if;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

  modport slave (
    input  hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing source for the 640x480@60 display path.
// Ports:
//   vga_clk  in   pixel clock, all logic on posedge
//   reset    in   synchronous active-high reset
//   en       in   pixel advance enable (tie 1 for a native 25 MHz clock)
//   vga      out  vga_timing_gen_if.master: hs, vs, blank, DrawX, DrawY,
//                 line_start, frame_start, frame_count
// Configuration macro VGA_SYNC_PIPE_EN: when defined, hs/vs get one extra
// free-running register stage so sync lags DrawX/DrawY/blank by one clock.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               en,
  vga_timing_gen_if.master   vga
);

  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SSTART = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SEND   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SSTART = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SEND   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [15:0] fc_q, fc_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_wrap = (vc_q == V_LAST);
    hc_d   = hc_q;
    vc_d   = vc_q;
    fc_d   = fc_q;
    if (en) begin
      hc_d = h_wrap ? '0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = v_wrap ? '0 : vc_q + 10'd1;
        if (v_wrap) begin
          fc_d = fc_q + 16'd1;
        end
      end
    end

    // Decodes are taken from the next-state counters so the registered
    // versions line up with DrawX/DrawY. They only update on enabled edges,
    // which keeps the post-reset pixel (0,0) reported as blanked.
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (en) begin
      blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
      hs_d    = ((hc_d >= H_SSTART) && (hc_d < H_SEND)) ? SYNC_POL : ~SYNC_POL;
      vs_d    = ((vc_d >= V_SSTART) && (vc_d < V_SEND)) ? SYNC_POL : ~SYNC_POL;
    end

    // Strobes are not held by en: they drop on the very next clock.
    ls_d = en && h_wrap;
    fs_d = en && h_wrap && v_wrap;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      fc_q    <= '0;
      blank_q <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  // Extra sync stage for renderers that register colour one clock after
  // DrawX; runs every clock, independent of en.
  logic hs_p_q;
  logic vs_p_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_p_q <= ~SYNC_POL;
      vs_p_q <= ~SYNC_POL;
    end else begin
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
    end
  end

  assign vga.hs = hs_p_q;
  assign vga.vs = vs_p_q;
`else
  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
`endif

  assign vga.blank       = blank_q;
  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- randomized-enable bench for vga_timing_gen.
// Two instances share clock/reset/en: A uses the 640x480 defaults, B a tiny
// raster (25x19, active-high sync) so frame wraps and vsync occur often.
// The reference keeps a linear pixel index per instance and derives the
// expected outputs from it with plain arithmetic.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic en      = 1'b1;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();

  vga_timing_gen dut_a (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (en),
    .vga     (vga_a.master)
  );

  vga_timing_gen #(
    .H_VISIBLE (16),
    .H_FP      (2),
    .H_SYNC    (4),
    .H_BP      (3),
    .V_VISIBLE (12),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (3),
    .SYNC_POL  (1'b1)
  ) dut_b (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (en),
    .vga     (vga_b.master)
  );

  // Raster geometry per instance
  int HV[2] = '{640, 16};
  int HF[2] = '{16, 2};
  int HS[2] = '{96, 4};
  int HB[2] = '{48, 3};
  int VV[2] = '{480, 12};
  int VF[2] = '{10, 2};
  int VS[2] = '{2, 2};
  int VB[2] = '{33, 3};
  bit POL[2] = '{1'b0, 1'b1};

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: linear pixel index, frame count, "no enabled edge since
  // reset" flag, and whether the last edge advanced the raster.
  int p[2]        = '{0, 0};
  int fc[2]       = '{0, 0};
  bit fresh[2]    = '{1'b1, 1'b1};
  bit stepped[2]  = '{1'b0, 1'b0};
  bit hs_pipe[2]  = '{1'b0, 1'b1};
  bit vs_pipe[2]  = '{1'b0, 1'b1};
  bit started     = 1'b0;

  function automatic int htot(int k);
    return HV[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vtot(int k);
    return VV[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic bit exp_hs_level(int k);
    int x = p[k] % htot(k);
    bit act = !fresh[k] && (x >= HV[k] + HF[k]) && (x < HV[k] + HF[k] + HS[k]);
    return act ? POL[k] : !POL[k];
  endfunction

  function automatic bit exp_vs_level(int k);
    int y = p[k] / htot(k);
    bit act = !fresh[k] && (y >= VV[k] + VF[k]) && (y < VV[k] + VF[k] + VS[k]);
    return act ? POL[k] : !POL[k];
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge vga_clk) begin
    for (int k = 0; k < 2; k++) begin
      hs_pipe[k] = reset ? !POL[k] : exp_hs_level(k);
      vs_pipe[k] = reset ? !POL[k] : exp_vs_level(k);
      if (reset) begin
        p[k]       = 0;
        fc[k]      = 0;
        fresh[k]   = 1'b1;
        stepped[k] = 1'b0;
      end else if (en) begin
        p[k]       = (p[k] + 1) % (htot(k) * vtot(k));
        if (p[k] == 0) fc[k] = (fc[k] + 1) & 32'hFFFF;
        fresh[k]   = 1'b0;
        stepped[k] = 1'b1;
      end else begin
        stepped[k] = 1'b0;
      end
    end
    started = 1'b1;
  end

  task automatic check_inst(input int k, input string nm,
                            input logic [9:0] dx, input logic [9:0] dy,
                            input logic bl, input logic hs, input logic vs,
                            input logic ls, input logic fs,
                            input logic [15:0] fcnt);
    int x = p[k] % htot(k);
    int y = p[k] / htot(k);
    bit exp_bl = !fresh[k] && (x < HV[k]) && (y < VV[k]);
    bit exp_hs, exp_vs;
`ifdef VGA_SYNC_PIPE_EN
    exp_hs = hs_pipe[k];
    exp_vs = vs_pipe[k];
`else
    exp_hs = exp_hs_level(k);
    exp_vs = exp_vs_level(k);
`endif
    check_value({nm, ".DrawX"}, 32'(dx), 32'(x));
    check_value({nm, ".DrawY"}, 32'(dy), 32'(y));
    check_value({nm, ".blank"}, 32'(bl), 32'(exp_bl));
    check_value({nm, ".hs"}, 32'(hs), 32'(exp_hs));
    check_value({nm, ".vs"}, 32'(vs), 32'(exp_vs));
    check_value({nm, ".line_start"}, 32'(ls), 32'(stepped[k] && x == 0));
    check_value({nm, ".frame_start"}, 32'(fs), 32'(stepped[k] && p[k] == 0));
    check_value({nm, ".frame_count"}, 32'(fcnt), 32'(fc[k]));
  endtask

  always @(negedge vga_clk) begin
    if (started) begin
      check_inst(0, "A", vga_a.DrawX, vga_a.DrawY, vga_a.blank, vga_a.hs,
                 vga_a.vs, vga_a.line_start, vga_a.frame_start,
                 vga_a.frame_count);
      check_inst(1, "B", vga_b.DrawX, vga_b.DrawY, vga_b.blank, vga_b.hs,
                 vga_b.vs, vga_b.line_start, vga_b.frame_start,
                 vga_b.frame_count);
    end
  end

  initial begin
    // Reset held for three edges with en high
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge vga_clk);

    // Free-running lines: covers line wrap, blank edge and the hsync window
    reset = 1'b0;
    repeat (2400) @(negedge vga_clk);

    // Alternating enable
    repeat (20) begin
      en = ~en;
      @(negedge vga_clk);
    end
    en = 1'b1;

    // Random enable with occasional reset
    repeat (30000) begin
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 4999) == 0);
      @(negedge vga_clk);
    end

    // Mid-frame reset with random en, then idle with en low before resuming
    en    = 1'($urandom_range(0, 1));
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
    en    = 1'b0;
    repeat (5) @(negedge vga_clk);
    en = 1'b1;
    repeat (20000) @(negedge vga_clk);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
